// File: rtl/ttc_sync_if.sv
`default_nettype none
// ttc_sync_if: TTC strobes, BXN preset and synchroniser status bundle.
// Revision 1.0
interface ttc_sync_if #(
  parameter int MXBXN = 12,
  parameter int MXCNT = 32,
  parameter int MXERR = 16
) ();
  logic             ttc_bx0;
  logic             ttc_resync;
  logic             err_cnt_reset;
  logic [MXBXN-1:0] bxn_offset;
  logic [MXBXN-1:0] bxn_counter;
  logic [MXCNT-1:0] orbit_counter;
  logic             bx0_local;
  logic             bxn_sync;
  logic             bxn_sync_err;
  logic             locked;
  logic [1:0]       sync_state;
  logic [MXERR-1:0] bx0_err_cnt;
  logic [MXERR-1:0] bx0_miss_cnt;
  logic [MXERR-1:0] resync_cnt;

  modport master (
    output ttc_bx0, ttc_resync, err_cnt_reset, bxn_offset,
    input  bxn_counter, orbit_counter, bx0_local, bxn_sync, bxn_sync_err,
           locked, sync_state, bx0_err_cnt, bx0_miss_cnt, resync_cnt
  );

  modport slave (
    input  ttc_bx0, ttc_resync, err_cnt_reset, bxn_offset,
    output bxn_counter, orbit_counter, bx0_local, bxn_sync, bxn_sync_err,
           locked, sync_state, bx0_err_cnt, bx0_miss_cnt, resync_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ttc_sync.sv
`default_nettype none
// ttc_sync: bunch-crossing/orbit counter aligned to TTC bx0 with lock tracking and error counters.
// Revision 1.0
module ttc_sync #(
  parameter int MXBXN          = 12,
  parameter int LHC_CYCLE      = 3564,
  parameter int MXCNT          = 32,
  parameter int MXERR          = 16,
  parameter bit HOLD_UNTIL_BX0 = 1'b1,
  parameter int LOCK_COUNT     = 4,
  parameter int UNLOCK_COUNT   = 2
) (
  input  logic      clock,
  input  logic      reset,
  ttc_sync_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_SYNCING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [MXBXN-1:0] BXN_LAST    = MXBXN'(LHC_CYCLE - 1);
  localparam logic [MXCNT-1:0] ORBIT_MAX   = '1;
  localparam logic [MXERR-1:0] ERR_MAX     = '1;
  localparam logic [7:0]       LOCK_N      = 8'(LOCK_COUNT);
  localparam logic [7:0]       UNLOCK_N    = 8'(UNLOCK_COUNT);
  localparam state_t           RESET_STATE = HOLD_UNTIL_BX0 ? ST_HOLD : ST_SYNCING;

  state_t           state, state_nxt;
  logic [7:0]       good_run, good_run_nxt;
  logic [7:0]       bad_run, bad_run_nxt;
  logic [MXBXN-1:0] offset_lim;
  logic [MXBXN-1:0] bxn_counter;
  logic [MXCNT-1:0] orbit_counter;
  logic [MXERR-1:0] bx0_err_cnt, bx0_miss_cnt, resync_cnt;
  logic             bxn_sync_err;

  logic preset, bxn_sync, judge, good, early, miss, bad;

  assign preset   = ((HOLD_UNTIL_BX0 && (state == ST_HOLD)) || bus.ttc_resync) && !bus.ttc_bx0;
  assign bxn_sync = (bxn_counter == offset_lim);
  // Alignment is only judged on free-running cycles outside HOLD.
  assign judge    = !preset && !bus.ttc_resync && (state != ST_HOLD);
  assign good     = judge &&  bus.ttc_bx0 &&  bxn_sync;
  assign early    = judge &&  bus.ttc_bx0 && !bxn_sync;
  assign miss     = judge && !bus.ttc_bx0 &&  bxn_sync;
  assign bad      = early || miss;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RESET_STATE;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_nxt;
      good_run <= good_run_nxt;
      bad_run  <= bad_run_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    bad_run_nxt  = bad_run;
    if (bus.ttc_resync) begin
      bad_run_nxt = '0;
      if (bus.ttc_bx0) begin
        state_nxt    = ST_SYNCING;
        good_run_nxt = 8'd1;
      end else begin
        state_nxt    = RESET_STATE;
        good_run_nxt = '0;
      end
    end else begin
      case (state)
        ST_HOLD: begin
          if (bus.ttc_bx0) begin
            state_nxt    = ST_SYNCING;
            good_run_nxt = 8'd1;
            bad_run_nxt  = '0;
          end
        end
        ST_SYNCING: begin
          if (good) begin
            good_run_nxt = good_run + 8'd1;
            if (good_run_nxt == LOCK_N) begin
              state_nxt   = ST_LOCKED;
              bad_run_nxt = '0;
            end
          end else if (bad) begin
            good_run_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (good) begin
            bad_run_nxt = '0;
          end else if (bad) begin
            bad_run_nxt = bad_run + 8'd1;
            if (bad_run_nxt == UNLOCK_N) begin
              state_nxt    = ST_SYNCING;
              good_run_nxt = '0;
              bad_run_nxt  = '0;
            end
          end
        end
        default: begin
          state_nxt    = RESET_STATE;
          good_run_nxt = '0;
          bad_run_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      offset_lim    <= '0;
      bxn_counter   <= '0;
      orbit_counter <= '0;
      bxn_sync_err  <= 1'b0;
      bx0_err_cnt   <= '0;
      bx0_miss_cnt  <= '0;
      resync_cnt    <= '0;
    end else begin
      offset_lim <= (bus.bxn_offset > BXN_LAST) ? BXN_LAST : bus.bxn_offset;

      if (preset)
        bxn_counter <= offset_lim;
      else if (bxn_counter == BXN_LAST)
        bxn_counter <= '0;
      else
        bxn_counter <= bxn_counter + MXBXN'(1);

      if (bus.ttc_resync)
        orbit_counter <= '0;
      else if (!preset && (bxn_counter == BXN_LAST) && (orbit_counter != ORBIT_MAX))
        orbit_counter <= orbit_counter + MXCNT'(1);

      // A bad event in the same cycle as a preset keeps the flag set.
      if (bad)
        bxn_sync_err <= 1'b1;
      else if (preset)
        bxn_sync_err <= 1'b0;

      if (bus.err_cnt_reset) begin
        bx0_err_cnt  <= '0;
        bx0_miss_cnt <= '0;
        resync_cnt   <= '0;
      end else begin
        if (early && (bx0_err_cnt != ERR_MAX))
          bx0_err_cnt <= bx0_err_cnt + MXERR'(1);
        if (miss && (bx0_miss_cnt != ERR_MAX))
          bx0_miss_cnt <= bx0_miss_cnt + MXERR'(1);
        if (bus.ttc_resync && (resync_cnt != ERR_MAX))
          resync_cnt <= resync_cnt + MXERR'(1);
      end
    end
  end

  assign bus.bxn_counter   = bxn_counter;
  assign bus.orbit_counter = orbit_counter;
  assign bus.bx0_local     = (bxn_counter == '0);
  assign bus.bxn_sync      = bxn_sync;
  assign bus.bxn_sync_err  = bxn_sync_err;
  assign bus.locked        = (state == ST_LOCKED);
  assign bus.sync_state    = state;
  assign bus.bx0_err_cnt   = bx0_err_cnt;
  assign bus.bx0_miss_cnt  = bx0_miss_cnt;
  assign bus.resync_cnt    = resync_cnt;

endmodule
`default_nettype wire

// File: doc/ttc_sync.md
TTC_SYNC -- requirements
Module: ttc_sync

Interface
REQ-001 SHALL have parameter MXBXN, default 12: BXN width.
REQ-002 SHALL have parameter LHC_CYCLE, default 3564: orbit length; BXN runs 0..LHC_CYCLE-1.
REQ-003 SHALL have parameter MXCNT, default 32: orbit counter width.
REQ-004 SHALL have parameter MXERR, default 16: error/resync counter width.
REQ-005 SHALL have parameter HOLD_UNTIL_BX0, default 1: hold BXN at offset until first ttc_bx0.
REQ-006 SHALL have parameter LOCK_COUNT, default 4 (1..255): consecutive good bx0 to lock.
REQ-007 SHALL have parameter UNLOCK_COUNT, default 2 (1..255): consecutive bad events to unlock.
REQ-008 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-009 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-010 SHALL have ports ttc_bx0, ttc_resync, err_cnt_reset  in  1 each  single-cycle strobes.
REQ-011 SHALL have port bxn_offset  in  MXBXN  BXN preset value.
REQ-012 SHALL have ports bxn_counter  out  MXBXN, and orbit_counter  out  MXCNT.
REQ-013 SHALL have ports bx0_local, bxn_sync, bxn_sync_err, locked  out  1 each.
REQ-014 SHALL have port sync_state  out  2  0=HOLD, 1=SYNCING, 2=LOCKED.
REQ-015 SHALL have ports bx0_err_cnt, bx0_miss_cnt, resync_cnt  out  MXERR each.

Function
REQ-016 SHALL register offset_lim = (bxn_offset >= LHC_CYCLE) ? LHC_CYCLE-1 : bxn_offset, one-cycle latency.
REQ-017 SHALL define preset = ((HOLD_UNTIL_BX0 && state==HOLD) || ttc_resync) && !ttc_bx0.
REQ-018 SHALL update bxn_counter with priority: preset -> offset_lim; ==LHC_CYCLE-1 -> 0; else +1.
REQ-019 SHALL drive bxn_sync = (bxn_counter==offset_lim) and bx0_local = (bxn_counter==0), combinational.
REQ-020 SHALL classify per cycle, only when !preset, !ttc_resync, state!=HOLD: good = ttc_bx0&&bxn_sync; early = ttc_bx0&&!bxn_sync; miss = bxn_sync&&!ttc_bx0; bad = early||miss.
REQ-021 SHALL, in HOLD on ttc_bx0 (no resync), go SYNCING with good_run=1.
REQ-022 SHALL, in SYNCING: good -> good_run+1, entering LOCKED when the incremented value reaches LOCK_COUNT; bad -> good_run=0.
REQ-023 SHALL, in LOCKED: good -> bad_run=0; bad -> bad_run+1; incremented value reaching UNLOCK_COUNT -> SYNCING, good_run=0, bad_run=0.
REQ-024 SHALL, on ttc_resync without ttc_bx0, go HOLD (HOLD_UNTIL_BX0=1) or SYNCING (=0), clearing both runs.
REQ-025 SHALL, on ttc_resync with ttc_bx0 same cycle, not preset the counter (it increments), go SYNCING with good_run=1.
REQ-026 SHALL set locked = (state==LOCKED), registered with state.
REQ-027 SHALL set bxn_sync_err on any bad event, hold until preset clears it; set wins if both in one cycle.
REQ-028 SHALL increment bx0_err_cnt on early, bx0_miss_cnt on miss, resync_cnt on each ttc_resync; all saturate at all-ones.
REQ-029 SHALL synchronously clear the three error/resync counters on err_cnt_reset, which beats a same-cycle increment.
REQ-030 SHALL increment orbit_counter when bxn_counter==LHC_CYCLE-1 and !preset, saturating at all-ones; cleared by ttc_resync (priority).

Reset
REQ-031 SHALL, on reset low, immediately and without a clock force: bxn_counter=0, orbit_counter=0, offset_lim=0, runs=0, error counters=0, bxn_sync_err=0, locked=0, state=HOLD (HOLD_UNTIL_BX0=1) or SYNCING (=0).
REQ-032 SHALL resume counting on the first clock edge after reset deassertion, with no other startup delay.

Verification
REQ-033 SHALL verify lock: offset=160, reset released, HOLD -> bxn_counter 160 by cycle 2; ttc_bx0 -> 161 next cycle, SYNCING; three more bx0 at 3564-cycle spacing -> locked=1 on 4th bx0 edge.
REQ-034 SHALL verify clamp/wrap: bxn_offset=4000 -> held at 3563; ttc_bx0 -> bxn_counter=0, orbit_counter=1, bx0_local=1 next cycle.
REQ-035 SHALL verify unlock: locked, bx0 delayed one cycle -> bx0_miss_cnt=1 then bx0_err_cnt=1, bxn_sync_err=1, state SYNCING after 2nd event.
REQ-036 SHALL verify simultaneous resync+bx0 at counter 500 -> counter 501, orbit_counter=0, SYNCING, good_run=1, resync_cnt=1, bxn_sync_err cleared only by a later preset.
REQ-037 SHALL verify saturation: MXERR=4, 20 miss events -> bx0_miss_cnt=15; err_cnt_reset -> 0 next cycle.
REQ-038 SHALL verify async reset mid-count at bxn_counter=2000 with clock stopped -> all outputs at reset values before next edge.
